// File: rtl/sodor5_verif.sv
// Sodor 5-stage RV32I R-type pipeline run in lockstep with a single-cycle reference model.
// Commit at WB 3 edges after capture, regfile write at the 4th; no backpressure, one instruction per cycle.

module sodor5_alu #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [2:0]      i_funct3,
  input  logic            i_f7b5,
  output logic [XLEN-1:0] o_y
);
  always_comb begin
    o_y = '0;
    case (i_funct3)
      3'b000: o_y = i_f7b5 ? (i_a - i_b) : (i_a + i_b);
      3'b001: o_y = i_a << i_b[4:0];
      3'b010: o_y = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      3'b011: o_y = {{(XLEN-1){1'b0}}, i_a < i_b};
      3'b100: o_y = i_a ^ i_b;
      3'b101: begin
        // kept as an if so the signed shift is not widened into an unsigned ternary
        if (i_f7b5) o_y = $signed(i_a) >>> i_b[4:0];
        else        o_y = i_a >> i_b[4:0];
      end
      3'b110: o_y = i_a | i_b;
      default: o_y = i_a & i_b;
    endcase
  end
endmodule

module sodor5_dpath #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_vld,
  input  logic [4:0]      i_rd,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [2:0]      i_funct3,
  input  logic            i_f7b5,
  output logic            o_commit_valid,
  output logic [4:0]      o_commit_rd,
  output logic [XLEN-1:0] o_commit_data
);
  logic [XLEN-1:0] regfile [NUM_REGS];

  logic            r_id_wen, r_id_f7b5, r_ex_wen, r_ex_f7b5, r_mem_wen, r_wb_wen;
  logic [4:0]      r_id_rd, r_id_rs1, r_id_rs2, r_ex_rd, r_mem_rd, r_wb_rd;
  logic [2:0]      r_id_funct3, r_ex_funct3;
  logic [XLEN-1:0] r_ex_a, r_ex_b, r_mem_data, r_wb_data;
  logic [XLEN-1:0] w_id_a, w_id_b, w_ex_alu;

  // Producers only carry wen when rd!=0, so a match here can never forward into x0.
  always_comb begin
    w_id_a = (r_id_rs1 == 5'd0) ? '0 : regfile[r_id_rs1];
    w_id_b = (r_id_rs2 == 5'd0) ? '0 : regfile[r_id_rs2];
    if (r_wb_wen  && r_wb_rd  == r_id_rs1) w_id_a = r_wb_data;
    if (r_mem_wen && r_mem_rd == r_id_rs1) w_id_a = r_mem_data;
    if (r_ex_wen  && r_ex_rd  == r_id_rs1) w_id_a = w_ex_alu;
    if (r_wb_wen  && r_wb_rd  == r_id_rs2) w_id_b = r_wb_data;
    if (r_mem_wen && r_mem_rd == r_id_rs2) w_id_b = r_mem_data;
    if (r_ex_wen  && r_ex_rd  == r_id_rs2) w_id_b = w_ex_alu;
  end

  sodor5_alu #(.XLEN(XLEN)) u_alu (
    .i_a      (r_ex_a),
    .i_b      (r_ex_b),
    .i_funct3 (r_ex_funct3),
    .i_f7b5   (r_ex_f7b5),
    .o_y      (w_ex_alu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_wen    <= 1'b0;
      r_id_rd     <= '0;
      r_id_rs1    <= '0;
      r_id_rs2    <= '0;
      r_id_funct3 <= '0;
      r_id_f7b5   <= 1'b0;
      r_ex_wen    <= 1'b0;
      r_ex_rd     <= '0;
      r_ex_a      <= '0;
      r_ex_b      <= '0;
      r_ex_funct3 <= '0;
      r_ex_f7b5   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_data  <= '0;
      r_wb_wen    <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
    end else begin
      r_id_wen    <= i_vld && (i_rd != 5'd0);
      r_id_rd     <= i_rd;
      r_id_rs1    <= i_rs1;
      r_id_rs2    <= i_rs2;
      r_id_funct3 <= i_funct3;
      r_id_f7b5   <= i_f7b5;
      r_ex_wen    <= r_id_wen;
      r_ex_rd     <= r_id_rd;
      r_ex_a      <= w_id_a;
      r_ex_b      <= w_id_b;
      r_ex_funct3 <= r_id_funct3;
      r_ex_f7b5   <= r_id_f7b5;
      r_mem_wen   <= r_ex_wen;
      r_mem_rd    <= r_ex_rd;
      r_mem_data  <= w_ex_alu;
      r_wb_wen    <= r_mem_wen;
      r_wb_rd     <= r_mem_rd;
      r_wb_data   <= r_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (r_wb_wen) regfile[r_wb_rd] <= r_wb_data;
  end

  assign o_commit_valid = r_wb_wen;
  assign o_commit_rd    = r_wb_rd;
  assign o_commit_data  = r_wb_data;
endmodule

module sodor5_core #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     i_instr,
  output logic            o_commit_valid,
  output logic [4:0]      o_commit_rd,
  output logic [XLEN-1:0] o_commit_data
);
  logic w_is_rtype;
  logic w_unused_f7;

  assign w_is_rtype  = (i_instr[6:0] == 7'b0110011);
  assign w_unused_f7 = ^{i_instr[31], i_instr[29:25]};

  sodor5_dpath #(.NUM_REGS(NUM_REGS), .XLEN(XLEN)) d (
    .clk            (clk),
    .reset          (reset),
    .i_vld          (w_is_rtype),
    .i_rd           (i_instr[11:7]),
    .i_rs1          (i_instr[19:15]),
    .i_rs2          (i_instr[24:20]),
    .i_funct3       (i_instr[14:12]),
    .i_f7b5         (i_instr[30]),
    .o_commit_valid (o_commit_valid),
    .o_commit_rd    (o_commit_rd),
    .o_commit_data  (o_commit_data)
  );
endmodule

module sodor5_dmem #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [3:0]      i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata
);
  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  assign o_rdata = mem[i_addr];
endmodule

module sodor5_coretop #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     i_instr,
  output logic            o_commit_valid,
  output logic [4:0]      o_commit_rd,
  output logic [XLEN-1:0] o_commit_data
);
  logic [XLEN-1:0] w_unused_dmem_rdata;

  sodor5_core #(.NUM_REGS(NUM_REGS), .XLEN(XLEN)) core (
    .clk            (clk),
    .reset          (reset),
    .i_instr        (i_instr),
    .o_commit_valid (o_commit_valid),
    .o_commit_rd    (o_commit_rd),
    .o_commit_data  (o_commit_data)
  );

  // R-type never touches data memory; the port is parked.
  sodor5_dmem #(.DEPTH(16), .XLEN(XLEN)) dmem (
    .clk     (clk),
    .i_we    (1'b0),
    .i_addr  (4'd0),
    .i_wdata ('0),
    .o_rdata (w_unused_dmem_rdata)
  );
endmodule

module sodor5_model #(
  parameter int NUM_REGS   = 32,
  parameter int XLEN       = 32,
  parameter int PIPE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     i_instr,
  output logic            o_vld,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_data
);
  logic [XLEN-1:0] regfile [NUM_REGS];

  logic            w_wen, w_unused_f7;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0] w_a, w_b, w_res;

  logic            r_dl_vld  [PIPE_DEPTH];
  logic [4:0]      r_dl_rd   [PIPE_DEPTH];
  logic [XLEN-1:0] r_dl_data [PIPE_DEPTH];

  assign w_rd        = i_instr[11:7];
  assign w_rs1       = i_instr[19:15];
  assign w_rs2       = i_instr[24:20];
  assign w_wen       = (i_instr[6:0] == 7'b0110011) && (w_rd != 5'd0);
  assign w_a         = (w_rs1 == 5'd0) ? '0 : regfile[w_rs1];
  assign w_b         = (w_rs2 == 5'd0) ? '0 : regfile[w_rs2];
  assign w_unused_f7 = ^{i_instr[31], i_instr[29:25]};

  sodor5_alu #(.XLEN(XLEN)) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_funct3 (i_instr[14:12]),
    .i_f7b5   (i_instr[30]),
    .o_y      (w_res)
  );

  always_ff @(posedge clk) begin
    if (!reset && w_wen) regfile[w_rd] <= w_res;
  end

  // Shift register whose head lines up with the core WB stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_dl_vld[i]  <= 1'b0;
        r_dl_rd[i]   <= '0;
        r_dl_data[i] <= '0;
      end
    end else begin
      r_dl_vld[0]  <= w_wen;
      r_dl_rd[0]   <= w_rd;
      r_dl_data[0] <= w_res;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_dl_vld[i]  <= r_dl_vld[i-1];
        r_dl_rd[i]   <= r_dl_rd[i-1];
        r_dl_data[i] <= r_dl_data[i-1];
      end
    end
  end

  assign o_vld  = r_dl_vld[PIPE_DEPTH-1];
  assign o_rd   = r_dl_rd[PIPE_DEPTH-1];
  assign o_data = r_dl_data[PIPE_DEPTH-1];
endmodule

module sodor5_verif #(
  parameter int NUM_REGS   = 32,
  parameter int XLEN       = 32,
  parameter int PIPE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  output logic            commit_valid,
  output logic [4:0]      commit_rd,
  output logic [XLEN-1:0] commit_data,
  output logic            mismatch,
  output logic [31:0]     commit_count
);
  logic            w_ref_vld, w_diff;
  logic [4:0]      w_ref_rd;
  logic [XLEN-1:0] w_ref_data;
  logic            r_mismatch;
  logic [31:0]     r_commit_count;

  sodor5_coretop #(.NUM_REGS(NUM_REGS), .XLEN(XLEN)) coretop (
    .clk            (clk),
    .reset          (reset),
    .i_instr        (instr),
    .o_commit_valid (commit_valid),
    .o_commit_rd    (commit_rd),
    .o_commit_data  (commit_data)
  );

  sodor5_model #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .PIPE_DEPTH(PIPE_DEPTH)) s5m (
    .clk     (clk),
    .reset   (reset),
    .i_instr (instr),
    .o_vld   (w_ref_vld),
    .o_rd    (w_ref_rd),
    .o_data  (w_ref_data)
  );

  assign w_diff = (commit_valid || w_ref_vld) &&
                  ((commit_valid != w_ref_vld) || (commit_rd != w_ref_rd) ||
                   (commit_data != w_ref_data));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mismatch     <= 1'b0;
      r_commit_count <= '0;
    end else begin
      r_mismatch     <= r_mismatch | w_diff;
      r_commit_count <= r_commit_count + 32'(commit_valid);
    end
  end

  assign mismatch     = r_mismatch;
  assign commit_count = r_commit_count;
endmodule

// File: tb/tb_sodor5_verif.sv
// Directed and random R-type streams against an architectural model kept in the bench.
module tb_sodor5_verif;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = NOP;
  logic        commit_valid, mismatch;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, commit_count;

  sodor5_verif dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .mismatch     (mismatch),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mm_from = 1 << 30;
  int exp_count = 0;

  logic [31:0] ref_rf  [32];
  logic        slot_v  [1024];
  logic [4:0]  slot_rd [1024];
  logic [31:0] slot_d  [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic alt);
    int unsigned sh;
    logic [31:0] r;
    sh = b[4:0];
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a >> sh;
        if (alt && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic setreg(input int idx, input logic [31:0] v);
    dut.coretop.core.d.regfile[idx] = v;
    dut.s5m.regfile[idx] = v;
    ref_rf[idx] = v;
  endtask

  // One edge: the bench model executes what the DUT samples and books its WB slot.
  task automatic tick(input logic [31:0] ins);
    logic [31:0] a, b;
    int e;
    instr = ins;
    @(posedge clk);
    e = cyc;
    if (reset) begin
      for (int j = 0; j < 4; j++) slot_v[(e + j) % 1024] = 1'b0;
    end else begin
      slot_v[(e + 3) % 1024] = 1'b0;
      if (ins[6:0] == 7'h33 && ins[11:7] != 5'd0) begin
        a = (ins[19:15] == 5'd0) ? 32'd0 : ref_rf[ins[19:15]];
        b = (ins[24:20] == 5'd0) ? 32'd0 : ref_rf[ins[24:20]];
        ref_rf[ins[11:7]] = golden(a, b, ins[14:12], ins[30]);
        slot_v[(e + 3) % 1024]  = 1'b1;
        slot_rd[(e + 3) % 1024] = ins[11:7];
        slot_d[(e + 3) % 1024]  = ref_rf[ins[11:7]];
      end
    end
    cyc = cyc + 1;
    #1;
  endtask

  task automatic nops(input int n);
    repeat (n) tick(NOP);
  endtask

  always @(negedge clk) begin
    int k;
    k = cyc - 1;
    if (reset) begin
      chk("rst_commit_valid", commit_valid, 32'd0);
      chk("rst_commit_rd", commit_rd, 32'd0);
      chk("rst_commit_data", commit_data, 32'd0);
      chk("rst_commit_count", commit_count, 32'd0);
      chk("rst_mismatch", mismatch, 32'd0);
      exp_count = 0;
    end else if (k >= 0) begin
      chk("commit_valid", commit_valid, slot_v[k % 1024]);
      if (slot_v[k % 1024]) begin
        chk("commit_rd", commit_rd, slot_rd[k % 1024]);
        chk("commit_data", commit_data, slot_d[k % 1024]);
      end
      chk("commit_count", commit_count, exp_count);
      chk("mismatch", mismatch, (k >= mm_from) ? 32'd1 : 32'd0);
      if (slot_v[k % 1024]) exp_count++;
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) slot_v[i] = 1'b0;
    nops(2);
    for (int i = 0; i < 32; i++) setreg(i, 32'h1000 + i);
    setreg(0, 32'h0);
    setreg(1, 32'd5);
    setreg(2, 32'd7);
    for (int i = 0; i < 16; i++) dut.coretop.dmem.mem[i] = 32'hC0DE_0000 + i;
    nops(2);
    chk("reset_count", commit_count, 32'd0);
    reset = 1'b0;

    // Basic ADD: commit visible after edge 3, regfile after edge 4.
    tick(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    nops(3);
    chk("add_valid", commit_valid, 32'd1);
    chk("add_rd", commit_rd, 32'd3);
    chk("add_data", commit_data, 32'd12);
    nops(1);
    chk("add_core_x3", dut.coretop.core.d.regfile[3], 32'd12);
    chk("add_ref_x3", ref_rf[3], 32'd12);
    nops(1);

    // Dependence through EX, MEM and WB forwarding paths.
    for (int gap = 0; gap < 3; gap++) begin
      setreg(3, 32'h100);
      tick(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
      nops(gap);
      tick(rtype(7'h00, 5'd3, 5'd3, 3'd0, 5'd4));
      nops(3);
      chk("dep_rd", commit_rd, 32'd4);
      chk("dep_data", commit_data, 32'd24);
      nops(2);
    end

    // Signed compares and shifts.
    setreg(1, 32'hFFFF_FFFF); setreg(2, 32'd1); setreg(5, 32'h55); setreg(6, 32'h66);
    tick(rtype(7'h00, 5'd2, 5'd1, 3'd2, 5'd5));
    tick(rtype(7'h00, 5'd2, 5'd1, 3'd3, 5'd6));
    nops(5);
    chk("slt_core", dut.coretop.core.d.regfile[5], 32'd1);
    chk("sltu_core", dut.coretop.core.d.regfile[6], 32'd0);
    chk("slt_ref", ref_rf[5], 32'd1);
    chk("sltu_ref", ref_rf[6], 32'd0);
    setreg(1, 32'h8000_0000); setreg(2, 32'd4);
    tick(rtype(7'h20, 5'd2, 5'd1, 3'd5, 5'd7));
    tick(rtype(7'h00, 5'd2, 5'd1, 3'd5, 5'd8));
    nops(5);
    chk("sra_core", dut.coretop.core.d.regfile[7], 32'hF800_0000);
    chk("srl_core", dut.coretop.core.d.regfile[8], 32'h0800_0000);
    chk("sra_ref", ref_rf[7], 32'hF800_0000);
    chk("srl_ref", ref_rf[8], 32'h0800_0000);

    // x0 reads as zero and is never written.
    setreg(0, 32'hDEAD_BEEF); setreg(1, 32'd5); setreg(2, 32'd7);
    tick(rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd5));
    tick(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd0));
    nops(2);
    chk("x0_src_rd", commit_rd, 32'd5);
    chk("x0_src_data", commit_data, 32'd0);
    nops(1);
    chk("x0_dst_valid", commit_valid, 32'd0);
    nops(2);
    chk("x0_core_kept", dut.coretop.core.d.regfile[0], 32'hDEAD_BEEF);

    // Diverged regfiles must raise the sticky mismatch one edge after WB.
    dut.coretop.core.d.regfile[20] = 32'd1;
    dut.s5m.regfile[20] = 32'd2;
    ref_rf[20] = 32'd1;
    tick(rtype(7'h00, 5'd0, 5'd20, 3'd0, 5'd21));
    mm_from = cyc - 1 + 4;
    nops(6);
    chk("mismatch_sticky", mismatch, 32'd1);

    // Reset with three ADDs in flight.
    setreg(10, 32'hA0A0_A0A0);
    tick(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd10));
    tick(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd11));
    tick(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd12));
    reset = 1'b1;
    mm_from = 1 << 30;
    tick(NOP);
    reset = 1'b0;
    nops(5);
    chk("midrst_count", commit_count, 32'd0);
    chk("midrst_mismatch", mismatch, 32'd0);
    chk("midrst_core_x10", dut.coretop.core.d.regfile[10], 32'hA0A0_A0A0);
    chk("midrst_model_x10", dut.s5m.regfile[10], 32'd12);

    // Random R-type stream.
    for (int i = 1; i < 32; i++) setreg(i, $urandom);
    for (int n = 0; n < 100; n++)
      tick(rtype(7'h00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))));
    nops(4);
    for (int i = 0; i < 32; i++) begin
      chk("rand_core_rf", dut.coretop.core.d.regfile[i], ref_rf[i]);
      chk("rand_model_rf", dut.s5m.regfile[i], ref_rf[i]);
    end
    nops(2);

    for (int i = 0; i < 16; i++) chk("dmem_kept", dut.coretop.dmem.mem[i], 32'hC0DE_0000 + i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
